// File: rtl/register_serial_tx.sv
// Serial transmitter: frames a WIDTH-bit word as start(0), data LSB-first, stop(1).
// Latency: start bit on tx the cycle after accept; frame is (WIDTH+2)*CLKS_PER_BIT cycles.
// Backpressure: load_ready is high only in IDLE; load_valid while busy is ignored.
module register_serial_tx #(
   parameter int WIDTH        = 7,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] d,
   output logic             load_ready,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   // bit counter wide enough for WIDTH-1, at least one bit
   localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   // cycle counter sized for the largest legal bit period (255)
   localparam logic [7:0]     CYC_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_nxt;
   logic [7:0]       cyc_cnt;
   logic [BCW-1:0]   bit_cnt;
   logic             accept;
   logic             bit_end;
   logic             tx_nxt;
   logic             done_nxt;

   assign accept     = load_valid && (state == IDLE);
   assign bit_end    = (cyc_cnt == CYC_LAST);
   assign load_ready = (state == IDLE);
   assign busy       = (state != IDLE);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: each non-idle phase advances at the end of its bit period
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load_valid)                       state_nxt = START;
         START:   if (bit_end)                          state_nxt = DATA;
         DATA:    if (bit_end && (bit_cnt == BIT_LAST)) state_nxt = STOP;
         STOP:    if (bit_end)                          state_nxt = IDLE;
         default:                                       state_nxt = IDLE;
      endcase
   end

   // Shift register next value: load on accept, shift right at each data bit boundary
   always_comb begin
      shift_nxt = shift_reg;
      if (accept) begin
         shift_nxt = d;
      end else if ((state == DATA) && bit_end) begin
         shift_nxt = shift_reg >> 1;
      end
   end

   // Cycle/bit counters and shift register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_cnt   <= 8'd0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         shift_reg <= shift_nxt;
         if ((state == IDLE) || bit_end) begin
            cyc_cnt <= 8'd0;
         end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
         end
         if ((state == DATA) && bit_end) begin
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BCW'(1);
         end else if (state != DATA) begin
            bit_cnt <= '0;
         end
      end
   end

   // Output decode from the upcoming state so tx and done can be registered
   always_comb begin
      tx_nxt   = 1'b1;
      done_nxt = 1'b0;
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift_nxt[0];
         default: tx_nxt = 1'b1;
      endcase
      if ((state != IDLE) && (state_nxt == IDLE)) begin
         done_nxt = 1'b1;
      end
   end

   // Registered serial line and completion pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx   <= 1'b1;
         done <= 1'b0;
      end else begin
         tx   <= tx_nxt;
         done <= done_nxt;
      end
   end

endmodule
